fio_mem_dump_streamer: RTL and testbench

Hardware read-back engine for the GPU's FileIO memory port. On a start request it sweeps a contiguous range of 256-bit MEM lines through the FIO read path and serialises each line into eight 32-bit words on a valid/ready stream, most-significant word first. This lets a host link or UART bridge retrieve results after `finished_TM_FIO` instead of a simulation-only dump loop. It sits between the FileIO read port of the top level and the host-side transmit channel.

---
 rtl/fio_mem_dump_streamer_if.sv | 27 ++
 rtl/fio_mem_dump_streamer.sv | 99 +++++++++
 tb/tb_fio_mem_dump_streamer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fio_mem_dump_streamer_if.sv
// Stream and FileIO read-port bundle for the memory dump streamer.
// The master side is the streamer; the slave side is the host/BRAM environment.
interface fio_mem_dump_streamer_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  start;
    logic                  clear;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] fio_addr;
    logic                  fio_rd_en;
    logic [255:0]          fio_rd_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [31:0]           m_data;
    logic                  m_last;

    modport master (
        input  start, clear, fio_rd_data, m_ready,
        output busy, done, fio_addr, fio_rd_en, m_valid, m_data, m_last
    );

    modport slave (
        output start, clear, fio_rd_data, m_ready,
        input  busy, done, fio_addr, fio_rd_en, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fio_mem_dump_streamer.sv
// Sweeps a range of 256-bit FIO lines and streams each as eight 32-bit words,
// most-significant word first, on a valid/ready channel.
module fio_mem_dump_streamer #(
    parameter int ADDR_WIDTH = 9,
    parameter int START_ADDR = 0,
    parameter int NUM_LINES  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    fio_mem_dump_streamer_if.master     bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    // Line counter is one bit wider so NUM_LINES = 2^ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]   LAST_LINE  = (ADDR_WIDTH+1)'(NUM_LINES - 1);
    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(START_ADDR);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   line_q, line_d;
    logic [2:0]            word_q, word_d;
    logic [255:0]          buf_q, buf_d;

    // NOTE: the line buffer is reset too, because m_data is taken straight from it
    // and must read as zero during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            line_q  <= '0;
            word_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            word_q  <= word_d;
            buf_q   <= buf_d;
        end
    end

    // NOTE: every next-state signal is defaulted to its current value first, so
    // no path through the case statement leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        line_d  = line_q;
        word_d  = word_q;
        buf_d   = buf_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    addr_d  = FIRST_ADDR;
                    line_d  = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: state_d = S_WAIT;
            S_WAIT: begin
                buf_d   = bus.fio_rd_data;
                word_d  = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (bus.m_ready) begin
                    // Shift so the outgoing word is always the top 32 bits.
                    buf_d  = {buf_q[223:0], 32'h0};
                    word_d = word_q + 3'd1;
                    if (word_q == 3'd7) begin
                        if (line_q == LAST_LINE) begin
                            state_d = S_DONE;
                        end else begin
                            line_d  = line_q + (ADDR_WIDTH+1)'(1);
                            addr_d  = addr_q + ADDR_WIDTH'(1);
                            state_d = S_ADDR;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.clear) state_d = S_IDLE;
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.fio_addr  = addr_q;
    assign bus.fio_rd_en = (state_q == S_ADDR);
    assign bus.m_valid   = (state_q == S_SEND);
    assign bus.m_data    = buf_q[255:224];
    assign bus.m_last    = (state_q == S_SEND) && (word_q == 3'd7) && (line_q == LAST_LINE);
endmodule

// File: tb/tb_fio_mem_dump_streamer.sv
// Directed bench for fio_mem_dump_streamer: three parameterisations share one
// clock, reset and stimulus path selected by `sel`.
module tb_fio_mem_dump_streamer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fio_mem_dump_streamer_if #(.ADDR_WIDTH(9)) ifa ();
    fio_mem_dump_streamer_if #(.ADDR_WIDTH(9)) ifb ();
    fio_mem_dump_streamer_if #(.ADDR_WIDTH(9)) ifc ();

    fio_mem_dump_streamer #(.ADDR_WIDTH(9), .START_ADDR(0),   .NUM_LINES(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    fio_mem_dump_streamer #(.ADDR_WIDTH(9), .START_ADDR(511), .NUM_LINES(2))  dut_b (.clk(clk), .rst(rst), .bus(ifb));
    fio_mem_dump_streamer #(.ADDR_WIDTH(9), .START_ADDR(0),   .NUM_LINES(1))  dut_c (.clk(clk), .rst(rst), .bus(ifc));

    // Line n holds word k = {n[7:0], 16'h0, k[7:0]} at bits [32k+31:32k].
    function automatic logic [255:0] line_data(input logic [8:0] a);
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[32*k +: 32] = {a[7:0], 16'h0, 8'(k)};
        return d;
    endfunction

    always @(posedge clk) if (ifa.fio_rd_en) ifa.fio_rd_data <= line_data(ifa.fio_addr);
    always @(posedge clk) if (ifb.fio_rd_en) ifb.fio_rd_data <= line_data(ifb.fio_addr);
    always @(posedge clk) if (ifc.fio_rd_en) ifc.fio_rd_data <= line_data(ifc.fio_addr);

    int   sel = 0;
    logic start_v = 1'b0, clear_v = 1'b0, ready_v = 1'b0;

    assign ifa.start = (sel == 0) && start_v;  assign ifa.clear = (sel == 0) && clear_v;  assign ifa.m_ready = (sel == 0) && ready_v;
    assign ifb.start = (sel == 1) && start_v;  assign ifb.clear = (sel == 1) && clear_v;  assign ifb.m_ready = (sel == 1) && ready_v;
    assign ifc.start = (sel == 2) && start_v;  assign ifc.clear = (sel == 2) && clear_v;  assign ifc.m_ready = (sel == 2) && ready_v;

    logic        o_busy, o_done, o_rd_en, o_valid, o_last;
    logic [8:0]  o_addr;
    logic [31:0] o_data;
    always_comb begin
        o_busy = ifa.busy; o_done = ifa.done; o_rd_en = ifa.fio_rd_en; o_valid = ifa.m_valid;
        o_last = ifa.m_last; o_addr = ifa.fio_addr; o_data = ifa.m_data;
        if (sel == 1) begin
            o_busy = ifb.busy; o_done = ifb.done; o_rd_en = ifb.fio_rd_en; o_valid = ifb.m_valid;
            o_last = ifb.m_last; o_addr = ifb.fio_addr; o_data = ifb.m_data;
        end else if (sel == 2) begin
            o_busy = ifc.busy; o_done = ifc.done; o_rd_en = ifc.fio_rd_en; o_valid = ifc.m_valid;
            o_last = ifc.m_last; o_addr = ifc.fio_addr; o_data = ifc.m_data;
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Results of the most recent stream() run.
    int          nw, nrd, ndone, seq_err, last_err, addr_err, stable_err;
    int          first_valid_c, last_c, done_c;
    logic [31:0] first_word;

    // Pulses start, then consumes words until done (or stop_after words).
    task automatic stream(input int lines, input int first_addr, input bit rnd,
                          input int stop_after, input bit inject_start);
        int          total;
        bit          stall_prev, xfer;
        logic [31:0] prev_data, exp;
        logic        prev_last;
        int          n, k;
        total = lines * 8;
        nw = 0; nrd = 0; ndone = 0; seq_err = 0; last_err = 0; addr_err = 0; stable_err = 0;
        first_valid_c = -1; last_c = -1; done_c = -1; first_word = '0;
        stall_prev = 1'b0; prev_data = '0; prev_last = 1'b0;
        @(negedge clk);
        start_v = 1'b1;
        for (int c = 1; c <= 5000; c++) begin
            @(negedge clk);
            start_v = inject_start && (nw == 40);
            if (o_done) begin ndone++; done_c = c; end
            if (o_rd_en) begin
                if (o_addr !== 9'((first_addr + nrd) % 512)) addr_err++;
                nrd++;
            end
            if (o_valid && first_valid_c < 0) first_valid_c = c;
            if (stall_prev && (!o_valid || o_data !== prev_data || o_last !== prev_last)) stable_err++;
            ready_v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            xfer = o_valid && ready_v;
            if (xfer) begin
                n   = (first_addr + nw / 8) % 512;
                k   = 7 - (nw % 8);
                exp = {8'(n), 16'h0, 8'(k)};
                if (o_data !== exp) seq_err++;
                if (o_last !== (nw == total - 1)) last_err++;
                if (nw == 0) first_word = o_data;
                nw++;
                if (nw == total) last_c = c;
            end
            stall_prev = o_valid && !ready_v;
            prev_data  = o_data;
            prev_last  = o_last;
            if (stop_after > 0 && xfer && nw == stop_after) break;
            if (ndone > 0 && c > done_c + 2) break;
        end
        start_v = 1'b0;
    endtask

    task automatic check_run(input string tag, input int lines, input int exp_words);
        check({tag, "_words"},      nw,            exp_words);
        check({tag, "_seq_err"},    seq_err,       0);
        check({tag, "_last_err"},   last_err,      0);
        check({tag, "_stable_err"}, stable_err,    0);
        check({tag, "_rd_count"},   nrd,           lines);
        check({tag, "_addr_err"},   addr_err,      0);
        check({tag, "_done_count"}, ndone,         1);
        check({tag, "_done_lat"},   done_c - last_c, 1);
    endtask

    initial begin
        int dn;
        // Reset state, sampled while rst is still asserted.
        #2;
        check("rst_busy",    ifa.busy,      0);
        check("rst_done",    ifa.done,      0);
        check("rst_valid",   ifa.m_valid,   0);
        check("rst_data",    ifa.m_data,    0);
        check("rst_last",    ifa.m_last,    0);
        check("rst_rd_en",   ifa.fio_rd_en, 0);
        check("rst_addr",    ifa.fio_addr,  0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full default run, sink always ready.
        sel = 0;
        stream(16, 0, 1'b0, 0, 1'b0);
        check_run("a_full", 16, 128);
        check("a_first_word", first_word, 32'h0000_0007);
        check("a_first_valid", first_valid_c, 3);

        // Same data with a randomly stalling sink.
        stream(16, 0, 1'b1, 0, 1'b0);
        check_run("a_rand", 16, 128);

        // Start pulsed mid-run must be ignored.
        stream(16, 0, 1'b0, 0, 1'b1);
        check_run("a_start_busy", 16, 128);

        // Abort after 20 accepted words.
        stream(16, 0, 1'b0, 20, 1'b0);
        check("clr_words", nw, 20);
        @(negedge clk);
        check("clr_busy_before", o_busy, 1);
        clear_v = 1'b1;
        ready_v = 1'b0;
        @(negedge clk);
        clear_v = 1'b0;
        check("clr_valid", o_valid, 0);
        check("clr_busy",  o_busy,  0);
        dn = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_done) dn++;
        end
        check("clr_no_done", dn, 0);
        stream(16, 0, 1'b0, 0, 1'b0);
        check_run("clr_restart", 16, 128);
        check("clr_restart_first", first_word, 32'h0000_0007);

        // Asynchronous reset while a word is on offer.
        stream(16, 0, 1'b0, 5, 1'b0);
        check("ar_valid_before", o_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_busy",  o_busy,  0);
        check("ar_done",  o_done,  0);
        check("ar_valid", o_valid, 0);
        check("ar_data",  o_data,  0);
        check("ar_last",  o_last,  0);
        check("ar_rd_en", o_rd_en, 0);
        check("ar_addr",  o_addr,  0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Address wrap: lines 511 then 0.
        sel = 1;
        stream(2, 511, 1'b0, 0, 1'b0);
        check_run("b_wrap", 2, 16);
        check("b_first_word", first_word, 32'hFF00_0007);

        // Single line: latency and last/done placement.
        sel = 2;
        stream(1, 0, 1'b0, 0, 1'b0);
        check_run("c_one", 1, 8);
        check("c_first_valid", first_valid_c, 3);
        check("c_last_c", last_c - first_valid_c, 7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
